// File: rtl/game_pkg.sv
// Shared game definitions: state encoding decoded by the ball, paddle and
// display blocks, plus the counter widths used across the game datapath.
package game_pkg;

  localparam int STATE_W  = 3;
  localparam int SCORE_W  = 8;
  localparam int LIVES_W  = 3;
  localparam int BRICKS_W = 8;

  typedef enum logic [STATE_W-1:0] {
    MAIN_MENU   = 3'd0,
    SERVE       = 3'd1,
    PLAY        = 3'd2,
    LIFE_LOST   = 3'd3,
    LEVEL_CLEAR = 3'd4,
    END_SCREEN  = 3'd5
  } game_state_t;

  // Score increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pause_timer.sv
// Loadable down-counter that times the pauses after a lost ball and after
// a cleared level. A load gives exactly PAUSE_CYCLES cycles until done.
module pause_timer #(
  parameter int PAUSE_CYCLES = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int CNT_W = $clog2(PAUSE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PAUSE_CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             active;

  // Count down from the load value; go idle once zero has been presented.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      count  <= '0;
      active <= 1'b0;
    end else if (load) begin
      count  <= LOAD_VAL;
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) begin
        active <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  assign done = active && (count == '0);

endmodule

// File: rtl/game_controller.sv
// Top-level game sequencer: owns the game state, gates ball motion, keeps
// lives/score/bricks from collision pulses and times the post-event pauses.
module game_controller
  import game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int BRICKS       = 32,
  parameter int PAUSE_CYCLES = 25_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                brick_hit,
  input  logic                ball_lost,
  output logic [STATE_W-1:0]  state,
  output logic                ball_move,
  output logic                ball_load,
  output logic [LIVES_W-1:0]  lives,
  output logic [SCORE_W-1:0]  score,
  output logic [BRICKS_W-1:0] bricks_left,
  output logic                game_won
);

  localparam logic [LIVES_W-1:0]  LIVES_INIT  = LIVES_W'(LIVES);
  localparam logic [BRICKS_W-1:0] BRICKS_INIT = BRICKS_W'(BRICKS);

  game_state_t         state_q, state_d;
  logic                start_q;
  logic                start_edge;
  logic                last_brick;
  logic                pause_load;
  logic                pause_done;
  logic [LIVES_W-1:0]  lives_d;
  logic [SCORE_W-1:0]  score_d;
  logic [BRICKS_W-1:0] bricks_d;
  logic                won_d;

  assign state      = state_q;
  assign start_edge = start & ~start_q;
  // A hit on the final brick clears the level and overrides a simultaneous loss.
  assign last_brick = brick_hit && (bricks_left == 8'd1);
  // Arm the timer on the same edge that enters a pause state.
  assign pause_load = ((state_d == LIFE_LOST) || (state_d == LEVEL_CLEAR)) &&
                      (state_d != state_q);

  pause_timer #(
    .PAUSE_CYCLES(PAUSE_CYCLES)
  ) u_pause_timer (
    .clock(clock),
    .reset(reset),
    .load (pause_load),
    .done (pause_done)
  );

  // Next-state and next-counter logic for the game sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    lives_d  = lives;
    score_d  = score;
    bricks_d = bricks_left;
    won_d    = game_won;
    case (state_q)
      MAIN_MENU: begin
        if (start_edge) begin
          lives_d  = LIVES_INIT;
          score_d  = '0;
          bricks_d = BRICKS_INIT;
          won_d    = 1'b0;
          state_d  = SERVE;
        end
      end
      SERVE: begin
        if (start_edge) state_d = PLAY;
      end
      PLAY: begin
        if (brick_hit) begin
          bricks_d = bricks_left - 1'b1;
          score_d  = sat_inc(score);
          if (last_brick) state_d = LEVEL_CLEAR;
        end
        if (ball_lost && !last_brick) begin
          lives_d = lives - 1'b1;
          won_d   = 1'b0;
          if (lives == 3'd1) begin
            state_d = END_SCREEN;
          end else begin
            state_d = LIFE_LOST;
          end
        end
      end
      LIFE_LOST: begin
        if (pause_done) state_d = SERVE;
      end
      LEVEL_CLEAR: begin
        if (pause_done) begin
          state_d = END_SCREEN;
          won_d   = 1'b1;
        end
      end
      END_SCREEN: begin
        if (start_edge) state_d = MAIN_MENU;
      end
      default: state_d = MAIN_MENU;
    endcase
  end

  // Register state, counters and the decoded ball controls.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= MAIN_MENU;
      start_q     <= 1'b0;
      ball_move   <= 1'b0;
      ball_load   <= 1'b0;
      lives       <= LIVES_INIT;
      score       <= '0;
      bricks_left <= BRICKS_INIT;
      game_won    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      ball_move   <= (state_d == PLAY);
      ball_load   <= (state_d == SERVE) && (state_q != SERVE);
      lives       <= lives_d;
      score       <= score_d;
      bricks_left <= bricks_d;
      game_won    <= won_d;
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller with LIVES=3, BRICKS=3, PAUSE_CYCLES=4.
// The driver pushes the hand-derived expected outputs for every clock edge;
// the monitor pops one entry per edge and compares.
module tb_game_controller;
  import game_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       mv;
    logic       ld;
    logic [2:0] lv;
    logic [7:0] sc;
    logic [7:0] bl;
    logic       won;
  } obs_t;

  logic       clock;
  logic       reset;
  logic       start;
  logic       brick_hit;
  logic       ball_lost;
  logic [2:0] state;
  logic       ball_move;
  logic       ball_load;
  logic [2:0] lives;
  logic [7:0] score;
  logic [7:0] bricks_left;
  logic       game_won;

  obs_t  e;
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  localparam obs_t RESET_OBS = '{st: 3'd0, mv: 1'b0, ld: 1'b0, lv: 3'd3,
                                 sc: 8'd0, bl: 8'd3, won: 1'b0};

  game_controller #(
    .LIVES(3),
    .BRICKS(3),
    .PAUSE_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .brick_hit  (brick_hit),
    .ball_lost  (ball_lost),
    .state      (state),
    .ball_move  (ball_move),
    .ball_load  (ball_load),
    .lives      (lives),
    .score      (score),
    .bricks_left(bricks_left),
    .game_won   (game_won)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got st=%0d mv=%0d ld=%0d lv=%0d sc=%0d bl=%0d won=%0d, expected st=%0d mv=%0d ld=%0d lv=%0d sc=%0d bl=%0d won=%0d",
               name, got.st, got.mv, got.ld, got.lv, got.sc, got.bl, got.won,
               want.st, want.mv, want.ld, want.lv, want.sc, want.bl, want.won);
    end
  endtask

  // Queue the outputs expected after the coming edge, then let it happen.
  // Pulse inputs and the ball_load expectation drop back after each edge.
  task automatic tick(input string tag = "step");
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clock);
    e.ld      = 1'b0;
    brick_hit = 1'b0;
    ball_lost = 1'b0;
  endtask

  // Monitor: one registered output set per edge, compared just after it.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        obs_t  want;
        obs_t  got;
        string t;
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        got  = {state, ball_move, ball_load, lives, score, bricks_left, game_won};
        check(t, got, want);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
    e = RESET_OBS;
    @(negedge clock);
    tick("reset"); tick("reset");
    reset = 1'b0; tick("menu idle");

    // Start edge into SERVE; holding start must not advance further.
    start = 1'b1; e.st = SERVE; e.ld = 1'b1; tick("menu->serve");
    repeat (10) tick("start held");
    start = 1'b0; tick("start low");
    start = 1'b1; e.st = PLAY; e.mv = 1'b1; tick("serve->play");
    start = 1'b0; tick("play idle");

    // Clear all three bricks.
    brick_hit = 1'b1; e.sc = 8'd1; e.bl = 8'd2; tick("hit1");
    tick("play idle");
    brick_hit = 1'b1; e.sc = 8'd2; e.bl = 8'd1; tick("hit2");
    brick_hit = 1'b1; e.sc = 8'd3; e.bl = 8'd0; e.st = LEVEL_CLEAR; e.mv = 1'b0; tick("hit3 clear");
    start = 1'b1; tick("clear start ignored");
    start = 1'b0; tick("clear pause"); tick("clear pause");
    e.st = END_SCREEN; e.won = 1'b1; tick("clear->end");

    // Collisions ignored outside PLAY; restart reloads counters.
    brick_hit = 1'b1; tick("end hit ignored");
    ball_lost = 1'b1; tick("end lost ignored");
    start = 1'b1; e.st = MAIN_MENU; tick("end->menu");
    start = 1'b0; brick_hit = 1'b1; tick("menu hit ignored");
    start = 1'b1; e.st = SERVE; e.ld = 1'b1; e.lv = 3'd3; e.sc = 8'd0; e.bl = 8'd3; e.won = 1'b0;
    tick("menu->serve reload");
    start = 1'b0; brick_hit = 1'b1; tick("serve hit ignored");
    ball_lost = 1'b1; tick("serve lost ignored");
    start = 1'b1; e.st = PLAY; e.mv = 1'b1; tick("serve->play");
    start = 1'b0; tick("play idle");

    // Lose all three lives.
    ball_lost = 1'b1; e.st = LIFE_LOST; e.mv = 1'b0; e.lv = 3'd2; tick("lost1");
    brick_hit = 1'b1; start = 1'b1; tick("pause hit/start ignored");
    ball_lost = 1'b1; start = 1'b0; tick("pause lost ignored");
    tick("pause");
    e.st = SERVE; e.ld = 1'b1; tick("pause->serve");
    start = 1'b1; e.st = PLAY; e.mv = 1'b1; tick("serve->play");
    start = 1'b0; tick("play idle");
    ball_lost = 1'b1; e.st = LIFE_LOST; e.mv = 1'b0; e.lv = 3'd1; tick("lost2");
    repeat (3) tick("pause");
    e.st = SERVE; e.ld = 1'b1; tick("pause->serve");
    start = 1'b1; e.st = PLAY; e.mv = 1'b1; tick("serve->play");
    start = 1'b0; tick("play idle");
    ball_lost = 1'b1; e.st = END_SCREEN; e.mv = 1'b0; e.lv = 3'd0; tick("lost3 game over");
    tick("end hold");

    // Simultaneous hit and loss, first without and then with level clear.
    start = 1'b1; e.st = MAIN_MENU; tick("end->menu");
    start = 1'b0; tick("menu idle");
    start = 1'b1; e.st = SERVE; e.ld = 1'b1; e.lv = 3'd3; e.sc = 8'd0; e.bl = 8'd3; tick("menu->serve reload");
    start = 1'b0; tick("serve idle");
    start = 1'b1; e.st = PLAY; e.mv = 1'b1; tick("serve->play");
    start = 1'b0; tick("play idle");
    brick_hit = 1'b1; ball_lost = 1'b1;
    e.sc = 8'd1; e.bl = 8'd2; e.lv = 3'd2; e.st = LIFE_LOST; e.mv = 1'b0; tick("hit+lost no clear");
    repeat (3) tick("pause");
    e.st = SERVE; e.ld = 1'b1; tick("pause->serve");
    start = 1'b1; e.st = PLAY; e.mv = 1'b1; tick("serve->play");
    start = 1'b0; tick("play idle");
    brick_hit = 1'b1; e.sc = 8'd2; e.bl = 8'd1; tick("hit to last brick");
    brick_hit = 1'b1; ball_lost = 1'b1;
    e.sc = 8'd3; e.bl = 8'd0; e.st = LEVEL_CLEAR; e.mv = 1'b0; tick("hit+lost clear");
    repeat (3) tick("clear pause");
    e.st = END_SCREEN; e.won = 1'b1; tick("clear->end won");

    // Reset in the middle of a life-lost pause.
    start = 1'b1; e.st = MAIN_MENU; tick("end->menu");
    start = 1'b0; tick("menu idle");
    start = 1'b1; e.st = SERVE; e.ld = 1'b1; e.lv = 3'd3; e.sc = 8'd0; e.bl = 8'd3; e.won = 1'b0;
    tick("menu->serve reload");
    start = 1'b0; tick("serve idle");
    start = 1'b1; e.st = PLAY; e.mv = 1'b1; tick("serve->play");
    start = 1'b0; tick("play idle");
    ball_lost = 1'b1; e.st = LIFE_LOST; e.mv = 1'b0; e.lv = 3'd2; tick("lost before reset");
    tick("mid pause");
    reset = 1'b1; e = RESET_OBS; tick("reset mid pause"); tick("reset held");
    reset = 1'b0;
    repeat (6) tick("post reset idle");

    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
